mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one N-to-1 multiplexer between N requesters. It owns the mux select line, grants exactly one requester at a time, and routes that requester's data bit to the shared output. Grants are held until the owner finishes, withdraws, or exceeds a hold limit. It sits directly in front of the muxN datapath and replaces any externally driven select.

## Interface
- N, 8, number of requesters / mux inputs (N >= 2)
- SW, $clog2(N), select width (derived, not overridden)
- MAX_HOLD, 16, maximum cycles one grant may be held (>= 1)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N  request vector; bit i = requester i wants the output
- done  in  1  owner finished; honoured only while busy
- x  in  N  data inputs to the shared mux
- gnt  out  N  one-hot grant, registered
- sel  out  SW  mux select, registered, equals index of gnt bit
- busy  out  1  high while a grant is held
- y  out  1  shared output: x[sel] when busy, else 0 (combinational through mux)

## Operation
- States: IDLE, OWN.
- IDLE: gnt=0, busy=0. If req != 0, pick the first set bit searching upward from ptr, wrapping N-1 -> 0. Next cycle: state OWN, gnt=one-hot(winner), sel=winner, busy=1, hold=0, ptr=(winner+1) mod N.
- OWN: hold increments each cycle. Release when any of: done=1; req[sel]=0; hold == MAX_HOLD-1. On release: next cycle state IDLE, gnt=0, busy=0; sel keeps last value.
- Simultaneous release conditions: single release, no difference.
- req changes for non-owners during OWN: ignored until next IDLE.
- done while IDLE: ignored.
- After a release, the just-served requester has lowest priority (ptr already past it); if it is the only requester it is granted again.
- Reset: state IDLE, ptr=0, sel=0, gnt=0, busy=0, hold=0, y=0. Reset during OWN drops the grant on the next edge regardless of req/done.

## Timing
- Request-to-grant: 1 cycle (req sampled in IDLE, gnt/busy visible after next edge).
- Release-to-gnt-low: 1 cycle after the edge sampling done/withdraw/timeout.
- Mandatory one-cycle IDLE bubble between consecutive grants; back-to-back owners see gnt gap of exactly 1 cycle.
- Max ownership: MAX_HOLD cycles of busy=1 per grant.
- y follows x combinationally while busy; no added latency on data.
- Worst-case wait for a continuously requesting input: (N-1)*(MAX_HOLD+1) cycles.

## Structure
- Shared package mux_arb_pkg: state enum (IDLE, OWN); helper function for wrapped first-set-bit search from a start index.
- One sub-module: muxN instantiated with N, driven by sel, output gated by busy.
- Hold counter width $clog2(MAX_HOLD+1); ptr width SW; ptr wrap handled explicitly for non-power-of-two N.

## Test plan
- reset high 2 cycles with req=8'hFF, done=0 -> gnt=0, sel=0, busy=0, y=0; after reset low, gnt=8'b00000001 one cycle later.
- x=8'b10101100, req=8'b00000100 -> next cycle gnt=8'b00000100, sel=2, busy=1, y=1; set req=0 -> gnt=0, busy=0, y=0 one cycle later.
- req=8'hFF held, done pulsed one cycle after each grant -> grant order sel=0,1,2,...,7,0 with one IDLE cycle between each.
- MAX_HOLD=4, req=8'b00100001, done=0 -> sel=0 busy for exactly 4 cycles, 1 idle, then sel=5 for 4 cycles, then sel=0.
- N=5, req=5'b10001, ptr after serving index 4 -> next grant sel=0 (wrap-around correct for non-power-of-two).
- reset asserted mid-OWN (sel=3, hold=2) -> next edge gnt=0, busy=0, sel=0; first grant after release goes to lowest set req bit from 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Latency: n/a (declarations and a combinational search function only).
// Backpressure: n/a.
package mux_arb_pkg;

    // Arbiter owns the mux (OWN) or is waiting to pick a new owner (IDLE).
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Widest request vector the search helper handles; arbiters keep N <= MAXN.
    localparam int unsigned MAXN = 64;

    // Index of the first set bit of vec[n-1:0], scanning upward from start
    // and wrapping n-1 -> 0. Returns 0 when nothing is set; callers only use
    // the result when the vector is non-zero.
    function automatic int unsigned first_set_from(
        input logic [MAXN-1:0] vec,
        input int unsigned     start,
        input int unsigned     n
    );
        int unsigned idx;
        logic        found;
        first_set_from = 0;
        found          = 1'b0;
        for (int unsigned k = 0; k < MAXN; k++) begin
            if (k < n && !found) begin
                idx = start + k;
                // explicit wrap so non-power-of-two n is handled correctly
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (vec[idx[5:0]]) begin
                    found          = 1'b1;
                    first_set_from = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/muxN.sv
// N-to-1 single-bit data mux with an output enable.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output forced to 0 while en is low.
module muxN #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  x,
    input  logic [SW-1:0] sel,
    input  logic          en,
    output logic          y
);

    // Select x[sel] when enabled; out-of-range selects read as 0.
    always_comb begin
        y = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && sel == SW'(i)) begin
                y = x[i];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared N-to-1 mux: one-hot registered grant, select and busy.
// Latency: 1 cycle request-to-grant, 1 cycle release-to-idle, 0 cycles on data (x -> y).
// Backpressure: grant held until done, withdraw or MAX_HOLD cycles; one idle bubble between owners.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 done,
    input  logic [N-1:0]         x,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic                 busy,
    output logic                 y
);

    localparam int SW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t    state;
    logic [SW-1:0] ptr;
    logic [HW-1:0] hold;

    logic [SW-1:0] win;
    logic [SW-1:0] win_next_ptr;
    logic [N-1:0]  win_onehot;
    logic          release_now;

    // Winner of the wrapped search starting at ptr, plus its one-hot grant
    // and the pointer value that makes it lowest priority next time.
    always_comb begin
        win          = SW'(first_set_from(MAXN'(req), 32'(ptr), N));
        win_next_ptr = (win == SW'(N - 1)) ? '0 : win + 1'b1;
        win_onehot   = '0;
        win_onehot[win] = 1'b1;
    end

    // Any one of these ends the current grant; coincident causes act once.
    always_comb begin
        release_now = done || !req[sel] || (hold == HW'(MAX_HOLD - 1));
    end

    // Arbitration FSM: all outputs registered; sel keeps its value after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= OWN;
                        gnt   <= win_onehot;
                        sel   <= win;
                        busy  <= 1'b1;
                        hold  <= '0;
                        ptr   <= win_next_ptr;
                    end
                end
                OWN: begin
                    hold <= hold + 1'b1;
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    muxN #(
        .N  (N),
        .SW (SW)
    ) u_mux (
        .x   (x),
        .sel (sel),
        .en  (busy),
        .y   (y)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: three instances (N=8/MAX_HOLD=16, N=8/MAX_HOLD=4, N=5/MAX_HOLD=16).
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: n/a.
module tb_mux_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [7:0] req_a, x_a, gnt_a;
    logic       done_a, busy_a, y_a;
    logic [2:0] sel_a;

    logic [7:0] req_b, x_b, gnt_b;
    logic       done_b, busy_b, y_b;
    logic [2:0] sel_b;

    logic [4:0] req_c, x_c, gnt_c;
    logic       done_c, busy_c, y_c;
    logic [2:0] sel_c;

    mux_rr_arbiter #(.N(8), .MAX_HOLD(16)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .done(done_a), .x(x_a),
        .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .y(y_a)
    );

    mux_rr_arbiter #(.N(8), .MAX_HOLD(4)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .done(done_b), .x(x_b),
        .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .y(y_b)
    );

    mux_rr_arbiter #(.N(5), .MAX_HOLD(16)) dut_c (
        .clk(clk), .reset(reset), .req(req_c), .done(done_c), .x(x_c),
        .gnt(gnt_c), .sel(sel_c), .busy(busy_c), .y(y_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        int         inst;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int inst, input logic [7:0] g,
                        input logic [2:0] s, input logic b, input logic yy);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        e.y    = yy;
        sbq.push_back(e);
    endtask

    // Advance one clock and drain every expectation queued for this edge.
    task automatic step();
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            case (e.inst)
                0: begin
                    chk({e.tag, ".gnt"},  32'(gnt_a),  32'(e.gnt));
                    chk({e.tag, ".sel"},  32'(sel_a),  32'(e.sel));
                    chk({e.tag, ".busy"}, 32'(busy_a), 32'(e.busy));
                    chk({e.tag, ".y"},    32'(y_a),    32'(e.y));
                end
                1: begin
                    chk({e.tag, ".gnt"},  32'(gnt_b),  32'(e.gnt));
                    chk({e.tag, ".sel"},  32'(sel_b),  32'(e.sel));
                    chk({e.tag, ".busy"}, 32'(busy_b), 32'(e.busy));
                    chk({e.tag, ".y"},    32'(y_b),    32'(e.y));
                end
                default: begin
                    chk({e.tag, ".gnt"},  32'(gnt_c),  32'(e.gnt[4:0]));
                    chk({e.tag, ".sel"},  32'(sel_c),  32'(e.sel));
                    chk({e.tag, ".busy"}, 32'(busy_c), 32'(e.busy));
                    chk({e.tag, ".y"},    32'(y_c),    32'(e.y));
                end
            endcase
        end
    endtask

    // Reference model state for the randomized phase on instance A.
    logic m_own;
    int   m_sel, m_ptr, m_hold;

    initial begin
        logic [7:0] xv;
        int gs[3];

        reset  = 1'b1;
        req_a  = 8'hFF; done_a = 1'b0; x_a = 8'h00;
        req_b  = 8'h00; done_b = 1'b0; x_b = 8'h00;
        req_c  = 5'h00; done_c = 1'b0; x_c = 5'h00;

        // Reset held two cycles with every requester asking.
        push("rst0", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        push("rst1", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        push("first_gnt", 0, 8'h01, 3'd0, 1'b1, 1'b0);
        step();
        req_a = 8'h00;
        push("first_rel", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // Single requester 2, data routed through the mux, then withdraw.
        x_a   = 8'b10101100;
        req_a = 8'b00000100;
        push("single.gnt", 0, 8'b00000100, 3'd2, 1'b1, 1'b1);
        step();
        req_a = 8'h00;
        push("single.rel", 0, 8'h00, 3'd2, 1'b0, 1'b0);
        step();

        // Full rotation with done pulsed right after each grant.
        reset = 1'b1;
        push("rr.rst", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        xv    = 8'b10101100;
        x_a   = xv;
        req_a = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            int j;
            j = k % 8;
            done_a = 1'b0;
            push($sformatf("rr.gnt%0d", k), 0, 8'(1 << j), 3'(j), 1'b1, xv[j]);
            step();
            done_a = 1'b1;
            push($sformatf("rr.rel%0d", k), 0, 8'h00, 3'(j), 1'b0, 1'b0);
            step();
        end
        done_a = 1'b0;
        req_a  = 8'h00;

        // Hold-limit timeout on the MAX_HOLD=4 instance: 4 busy cycles, 1 idle.
        gs[0] = 0; gs[1] = 5; gs[2] = 0;
        x_b   = 8'b00100001;
        req_b = 8'b00100001;
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 4; c++) begin
                push($sformatf("hold.g%0d.c%0d", g, c), 1, 8'(1 << gs[g]), 3'(gs[g]), 1'b1, 1'b1);
                step();
            end
            push($sformatf("hold.idle%0d", g), 1, 8'h00, 3'(gs[g]), 1'b0, 1'b0);
            step();
        end
        req_b = 8'h00;

        // Non-power-of-two N: pointer wraps from 4 back to 0.
        gs[0] = 0; gs[1] = 4; gs[2] = 0;
        x_c   = 5'b10000;
        req_c = 5'b10001;
        for (int g = 0; g < 3; g++) begin
            done_c = 1'b0;
            push($sformatf("n5.gnt%0d", g), 2, 8'(1 << gs[g]), 3'(gs[g]), 1'b1, (gs[g] == 4));
            step();
            done_c = 1'b1;
            push($sformatf("n5.rel%0d", g), 2, 8'h00, 3'(gs[g]), 1'b0, 1'b0);
            step();
        end
        done_c = 1'b0;
        req_c  = 5'h00;

        // Reset in the middle of an ownership (sel=3, hold=2).
        x_a   = 8'b00011000;
        req_a = 8'b00001000;
        for (int c = 0; c < 3; c++) begin
            push($sformatf("midrst.own%0d", c), 0, 8'b00001000, 3'd3, 1'b1, 1'b1);
            step();
        end
        reset = 1'b1;
        req_a = 8'hFF;
        push("midrst.drop", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        req_a = 8'b01010000;
        push("midrst.regnt", 0, 8'b00010000, 3'd4, 1'b1, 1'b1);
        step();
        req_a = 8'h00;
        push("midrst.rel", 0, 8'h00, 3'd4, 1'b0, 1'b0);
        step();

        // done while idle changes nothing and does not block a new grant.
        done_a = 1'b1;
        push("idle_done", 0, 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        req_a = 8'b00000100;
        push("idle_done.gnt", 0, 8'b00000100, 3'd2, 1'b1, 1'b0);
        step();
        push("done.rel", 0, 8'h00, 3'd2, 1'b0, 1'b0);
        step();
        done_a = 1'b0;
        req_a  = 8'h00;

        // Randomized phase against a cycle model.
        reset = 1'b1;
        push("rnd.rst", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        reset  = 1'b0;
        m_own  = 1'b0;
        m_sel  = 0;
        m_ptr  = 0;
        m_hold = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 5) == 0) req_a = 8'($urandom);
            done_a = ($urandom_range(0, 7) == 0);
            x_a    = 8'($urandom);
            if (m_own) begin
                if (done_a || !req_a[m_sel] || m_hold == 15) begin
                    m_own = 1'b0;
                end else begin
                    m_hold++;
                end
            end else if (req_a != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int i;
                    i = (m_ptr + k) % 8;
                    if (req_a[i]) begin
                        m_sel = i;
                        break;
                    end
                end
                m_own  = 1'b1;
                m_hold = 0;
                m_ptr  = (m_sel + 1) % 8;
            end
            push($sformatf("rnd%0d", cyc), 0, m_own ? 8'(1 << m_sel) : 8'h00,
                 3'(m_sel), m_own, m_own ? x_a[m_sel] : 1'b0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
